// File: rtl/dmem_mmio_if.sv
// Data-memory bus between the single-cycle datapath and the dmem/MMIO stage.
// The datapath drives the address, store data and write strobe. The memory
// stage returns load data combinationally in the same cycle.
interface dmem_mmio_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/dmem_mmio.sv
// Data-memory stage: word-addressed data RAM plus memory-mapped GPIO and a
// 32-bit compare-match timer with interrupt. Loads are combinational. Stores
// commit on the rising clock edge. Stores to read-only or unmapped locations
// raise a sticky address-error flag.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_mmio_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq,
  output logic                  addr_err
);

  localparam int          AW         = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT    = 32'hFFFF_0010;
  localparam logic [31:0] A_CMP      = 32'hFFFF_0014;
  localparam logic [31:0] A_CTRL     = 32'hFFFF_0018;

  logic [31:0]           ram_r [RAM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_out_r;
  logic [GPIO_WIDTH-1:0] sync1_r;
  logic [GPIO_WIDTH-1:0] sync2_r;
  logic [31:0]           count_r;
  logic [31:0]           cmp_r;
  logic                  en_r;
  logic                  autoclr_r;
  logic                  status_r;
  logic                  ie_r;
  logic                  addr_err_r;

  logic [31:0]   waddr_s;
  logic [AW-1:0] ram_idx_s;
  logic          sel_ram_s;
  logic          sel_gout_s;
  logic          sel_gin_s;
  logic          sel_count_s;
  logic          sel_cmp_s;
  logic          sel_ctrl_s;
  logic          sel_bad_s;
  logic          match_s;
  logic [31:0]   gin_ext_s;
  logic [31:0]   gout_ext_s;
  logic [31:0]   rdata_s;

  assign waddr_s   = {bus.addr[31:2], 2'b00};
  assign ram_idx_s = bus.addr[AW+1:2];
  assign match_s   = en_r & (count_r == cmp_r);

  // Address decode: RAM window first, then the MMIO registers. Anything else is unmapped.
  always_comb begin
    sel_ram_s   = 1'b0;
    sel_gout_s  = 1'b0;
    sel_gin_s   = 1'b0;
    sel_count_s = 1'b0;
    sel_cmp_s   = 1'b0;
    sel_ctrl_s  = 1'b0;
    sel_bad_s   = 1'b0;
    if (bus.addr < RAM_BYTES) begin
      sel_ram_s = 1'b1;
    end else begin
      case (waddr_s)
        A_GPIO_OUT: sel_gout_s  = 1'b1;
        A_GPIO_IN:  sel_gin_s   = 1'b1;
        A_COUNT:    sel_count_s = 1'b1;
        A_CMP:      sel_cmp_s   = 1'b1;
        A_CTRL:     sel_ctrl_s  = 1'b1;
        default:    sel_bad_s   = 1'b1;
      endcase
    end
  end

  // Zero-extend the GPIO registers to bus width for the load path.
  always_comb begin
    gin_ext_s                   = 32'd0;
    gout_ext_s                  = 32'd0;
    gin_ext_s[GPIO_WIDTH-1:0]   = sync2_r;
    gout_ext_s[GPIO_WIDTH-1:0]  = gpio_out_r;
  end

  // Load mux: zero-latency read of the selected location. Unmapped locations read 0.
  always_comb begin
    rdata_s = 32'd0;
    if (sel_ram_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else if (sel_gout_s) begin
      rdata_s = gout_ext_s;
    end else if (sel_gin_s) begin
      rdata_s = gin_ext_s;
    end else if (sel_count_s) begin
      rdata_s = count_r;
    end else if (sel_cmp_s) begin
      rdata_s = cmp_r;
    end else if (sel_ctrl_s) begin
      rdata_s = {28'd0, ie_r, status_r, autoclr_r, en_r};
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.readdata = rdata_s;
  assign gpio_out     = gpio_out_r;
  assign addr_err     = addr_err_r;
  assign irq          = status_r & ie_r;

  // Data RAM store port. Contents are deliberately retained across reset,
  // but a store that coincides with reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // RAM contents retained; nothing to clear.
    end else if (bus.memwrite && sel_ram_s) begin
      ram_r[ram_idx_s] <= bus.writedata;
    end
  end

  // GPIO output register and two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_r <= '0;
      sync1_r    <= '0;
      sync2_r    <= '0;
    end else begin
      if (bus.memwrite && sel_gout_s) begin
        gpio_out_r <= bus.writedata[GPIO_WIDTH-1:0];
      end
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
    end
  end

  // Timer: a software COUNT write beats auto-clear and increment, and a match beats a W1C clear of STATUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r   <= 32'd0;
      cmp_r     <= 32'hFFFF_FFFF;
      en_r      <= 1'b0;
      autoclr_r <= 1'b0;
      status_r  <= 1'b0;
      ie_r      <= 1'b0;
    end else begin
      if (bus.memwrite && sel_count_s) begin
        count_r <= bus.writedata;
      end else if (match_s && autoclr_r) begin
        count_r <= 32'd0;
      end else if (en_r) begin
        count_r <= count_r + 32'd1;
      end
      if (bus.memwrite && sel_cmp_s) begin
        cmp_r <= bus.writedata;
      end
      if (bus.memwrite && sel_ctrl_s) begin
        en_r      <= bus.writedata[0];
        autoclr_r <= bus.writedata[1];
        ie_r      <= bus.writedata[3];
      end
      status_r <= match_s | (status_r & ~(bus.memwrite & sel_ctrl_s & bus.writedata[2]));
    end
  end

  // Sticky error for stores to the read-only GPIO input or to unmapped addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err_r <= 1'b0;
    end else if (bus.memwrite && (sel_gin_s || sel_bad_s)) begin
      addr_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio. The bench runs directed steps and then a
// randomized phase, and checks both against a memory-map reference model.
`timescale 1ns/1ps
module tb_dmem_mmio;
  localparam int RW = 64;
  localparam int GW = 8;
  localparam logic [31:0] A_GOUT = 32'hFFFF_0000;
  localparam logic [31:0] A_GIN  = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0010;
  localparam logic [31:0] A_CMP  = 32'hFFFF_0014;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0018;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] gpio_out;
  logic          irq;
  logic          addr_err;

  dmem_mmio_if bus();

  dmem_mmio #(.RAM_WORDS(RW), .GPIO_WIDTH(GW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: the architectural view of the memory map.
  logic [31:0]   m_ram [RW];
  logic [GW-1:0] m_gout, m_s1, m_s2;
  logic [31:0]   m_count, m_cmp;
  logic          m_en, m_ac, m_st, m_ie, m_aerr;
  logic [31:0]   m_w, m_next_count;
  logic          m_hit, m_next_st;

  // Reference model: one architectural step per clock edge, cleared at once by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_gout = '0; m_s1 = '0; m_s2 = '0;
      m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_ac = 1'b0; m_st = 1'b0; m_ie = 1'b0; m_aerr = 1'b0;
    end else begin
      m_w   = {bus.addr[31:2], 2'b00};
      m_hit = m_en && (m_count == m_cmp);
      if (bus.memwrite && m_w == A_CNT) m_next_count = bus.writedata;
      else if (m_hit && m_ac)           m_next_count = 32'd0;
      else if (m_en)                    m_next_count = m_count + 32'd1;
      else                              m_next_count = m_count;
      m_next_st = m_hit || (m_st && !(bus.memwrite && m_w == A_CTRL && bus.writedata[2]));
      if (bus.memwrite) begin
        if (m_w < RW * 4)       m_ram[m_w[7:2]] = bus.writedata;
        else if (m_w == A_GOUT) m_gout = bus.writedata[GW-1:0];
        else if (m_w == A_CMP)  m_cmp = bus.writedata;
        else if (m_w == A_CTRL) begin
          m_en = bus.writedata[0]; m_ac = bus.writedata[1]; m_ie = bus.writedata[3];
        end
        else if (m_w != A_CNT)  m_aerr = 1'b1;
      end
      m_count = m_next_count;
      m_st    = m_next_st;
      m_s2    = m_s1;
      m_s1    = gpio_in;
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < RW * 4) return m_ram[w[7:2]];
    case (w)
      A_GOUT:  return {24'd0, m_gout};
      A_GIN:   return {24'd0, m_s2};
      A_CNT:   return m_count;
      A_CMP:   return m_cmp;
      A_CTRL:  return {28'd0, m_ie, m_st, m_ac, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational load checked against the model, plus an optional known constant.
  task automatic rd(input string tag, input logic [31:0] a);
    bus.memwrite = 1'b0;
    bus.addr     = a;
    #1;
    chk(tag, bus.readdata, m_read(a));
  endtask

  task automatic rdk(input string tag, input logic [31:0] a, input logic [31:0] k);
    rd(tag, a);
    chk({tag, "_k"}, bus.readdata, k);
  endtask

  task automatic pins(input string tag);
    chk({tag, "_gpio_out"}, {24'd0, gpio_out}, {24'd0, m_gout});
    chk({tag, "_irq"},      {31'd0, irq},      {31'd0, m_st & m_ie});
    chk({tag, "_addr_err"}, {31'd0, addr_err}, {31'd0, m_aerr});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pick_addr(input int unsigned r);
    case (r % 9)
      0, 1:    return $urandom_range(0, RW * 4 - 1);
      2:       return A_GOUT | 32'($urandom_range(0, 3));
      3:       return A_GIN;
      4:       return A_CNT;
      5:       return A_CMP;
      6:       return A_CTRL | 32'($urandom_range(0, 3));
      7:       return 32'h0000_0100 + 32'($urandom_range(0, 255));
      default: return 32'hFFFF_0008;
    endcase
  endfunction

  int n;
  logic [31:0] a, d;

  initial begin
    bus.memwrite = 1'b0; bus.addr = 32'd0; bus.writedata = 32'd0;
    tick(2);
    reset = 1'b1;
    tick(1);

    // Reset state.
    rdk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rdk("rst_ctrl", A_CTRL, 32'd0);
    rdk("rst_count", A_CNT, 32'd0);
    chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);

    // Fill RAM so every word has a known value.
    for (int i = 0; i < RW; i++) wr(32'(i * 4), $urandom);

    // RAM write/readback, ignoring byte offset; unmapped read.
    wr(32'h0000_0008, 32'h1234_5678);
    rdk("ram_b", 32'h0000_000B, 32'h1234_5678);
    rdk("unmapped_rd", 32'h0000_0100, 32'd0);

    // GPIO output and input synchroniser latency.
    wr(A_GOUT, 32'h0000_00A5);
    chk("gout_a5", {24'd0, gpio_out}, 32'h0000_00A5);
    rdk("gout_rd", A_GOUT, 32'h0000_00A5);
    gpio_in = 8'h3C;
    rdk("gin_0", A_GIN, 32'd0);
    tick(1);
    rdk("gin_1", A_GIN, 32'd0);
    tick(1);
    rdk("gin_2", A_GIN, 32'h0000_003C);

    // Auto-clearing timer with interrupt.
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h0000_000B);
    rdk("t_c0", A_CNT, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      rdk("t_seq", A_CNT, 32'(k));
      chk("t_irq_lo", {31'd0, irq}, 32'd0);
    end
    tick(1);
    rdk("t_wrap0", A_CNT, 32'd0);
    rdk("t_status", A_CTRL, 32'h0000_000F);
    chk("t_irq_hi", {31'd0, irq}, 32'd1);
    n = 0;
    while (m_count != 32'd5 && n < 20) begin tick(1); n++; end
    chk("t_wait5", 32'(n < 20), 32'd1);
    wr(A_CTRL, 32'h0000_000F);
    rdk("t_setwins", A_CTRL, 32'h0000_000F);
    tick(2);
    wr(A_CTRL, 32'h0000_000F);
    rdk("t_w1c", A_CTRL, 32'h0000_000B);
    chk("t_irq_clr", {31'd0, irq}, 32'd0);

    // Free-running wrap, match without interrupt enable, COUNT write beats increment.
    wr(A_CTRL, 32'h0000_0004);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h0000_0001);
    rdk("w_fe", A_CNT, 32'hFFFF_FFFE);
    tick(1); rdk("w_ff", A_CNT, 32'hFFFF_FFFF);
    tick(1); rdk("w_00", A_CNT, 32'd0);
    tick(3); rdk("w_03", A_CNT, 32'd3);
    rdk("w_st0", A_CTRL, 32'h0000_0001);
    tick(1);
    rdk("w_04", A_CNT, 32'd4);
    rdk("w_st1", A_CTRL, 32'h0000_0005);
    chk("w_irq_masked", {31'd0, irq}, 32'd0);
    wr(A_CNT, 32'h0000_0010);
    rdk("w_cnt_wr", A_CNT, 32'h0000_0010);
    wr(A_CTRL, 32'h0000_0004);

    // Illegal stores leave state alone and latch the error flag.
    chk("e_pre", {31'd0, addr_err}, 32'd0);
    wr(A_GIN, 32'hFFFF_FFFF);
    wr(32'h8000_0000, 32'hDEAD_BEEF);
    chk("e_gout", {24'd0, gpio_out}, 32'h0000_00A5);
    rdk("e_ram", 32'h0000_0008, 32'h1234_5678);
    rdk("e_gin", A_GIN, 32'h0000_003C);
    chk("e_flag", {31'd0, addr_err}, 32'd1);
    tick(3);
    chk("e_sticky", {31'd0, addr_err}, 32'd1);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = GW'($urandom);
      case ($urandom_range(0, 5))
        0: wr(pick_addr($urandom), $urandom);
        1: wr(pick_addr($urandom), 32'($urandom_range(0, 15)));
        2: wr(A_CTRL, 32'($urandom_range(0, 15)));
        3: wr(($urandom_range(0, 1) == 0) ? A_CNT : A_CMP, 32'($urandom_range(0, 12)));
        default: tick(1);
      endcase
      pins("rnd");
      rd("rnd_rd_a", pick_addr($urandom));
      rd("rnd_rd_b", pick_addr($urandom));
    end

    // Asynchronous reset in the middle of a count; stores during reset are dropped.
    wr(A_CMP, 32'h0000_FFFF);
    wr(A_CTRL, 32'h0000_000B);
    tick(3);
    #2;
    reset = 1'b0;
    #1;
    rdk("r_count", A_CNT, 32'd0);
    rdk("r_cmp", A_CMP, 32'hFFFF_FFFF);
    rdk("r_ctrl", A_CTRL, 32'd0);
    chk("r_gpio_out", {24'd0, gpio_out}, 32'd0);
    chk("r_irq", {31'd0, irq}, 32'd0);
    chk("r_addr_err", {31'd0, addr_err}, 32'd0);
    wr(A_GOUT, 32'h0000_00FF);
    a = 32'h0000_0008;
    d = m_read(a);
    wr(a, ~d);
    chk("r_gout_drop", {24'd0, gpio_out}, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    rdk("r_ram_drop", a, d);
    rdk("r_after_cnt", A_CNT, 32'd0);
    pins("r_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
